uart_rx_cfg: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver in the TP2-UART datapath. It sits between the pad-side serial line and the RX FIFO/interface logic, and runs on the system clock with a baud-rate tick enable. Over the previous block it adds:
- configurable data width, oversampling and stop-bit count;
- input synchronisation and 3-sample majority voting;
- false-start rejection, framing-error and break handling;
- optional parity checking.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sampler.sv | 43 ++++
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: state encoding,
// majority-sample offsets and parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Tick-counter positions of the three majority samples within a bit
  function automatic int unsigned sample_early(input int unsigned os);
    return os / 2 - 1;
  endfunction

  function automatic int unsigned sample_mid(input int unsigned os);
    return os / 2;
  endfunction

  function automatic int unsigned sample_decide(input int unsigned os);
    return os / 2 + 1;
  endfunction

  function automatic bit rx_params_legal(input int unsigned data_bits,
                                         input int unsigned oversample,
                                         input int unsigned stop_bits,
                                         input int unsigned parity_odd);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && (oversample <= 32) && (oversample % 2 == 0) &&
           ((stop_bits == 1) || (stop_bits == 2)) && (parity_odd <= 1);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser plus 3-sample majority vote around
// the middle of each bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_s_tick,
  input  logic                          i_rx,
  input  logic [$clog2(OVERSAMPLE)-1:0] s,
  output logic                          rx_s,
  output logic                          vote
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_EARLY = SW'(sample_early(OVERSAMPLE));
  localparam logic [SW-1:0] S_MID   = SW'(sample_mid(OVERSAMPLE));

  logic rx_meta;
  logic smp_early;
  logic smp_mid;

  // Synchroniser resets to the idle level so reset never looks like a start bit
  always_ff @(posedge i_clock or posedge i_reset) begin : p_sync
    if (i_reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      smp_early <= 1'b1;
      smp_mid   <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      if (i_s_tick && (s == S_EARLY)) smp_early <= rx_s;
      if (i_s_tick && (s == S_MID))   smp_mid   <= rx_s;
    end
  end

  // Third sample is the live rx_s on the decision tick
  assign vote = (smp_early & smp_mid) | (smp_early & rx_s) | (smp_mid & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, oversampling, stop bits, break).
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_s_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done_tick,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_DECIDE    = SW'(sample_decide(OVERSAMPLE));
  localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

  if (!rx_params_legal(DATA_BITS, OVERSAMPLE, STOP_BITS, PARITY_ODD)) begin : g_bad_params
    $error("uart_rx_cfg: illegal parameter combination");
  end

  rx_state_t            state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_pend;
  logic                 rx_s;
  logic                 vote;
`ifdef UART_RX_PARITY_EN
  logic                 parity_pend;
`endif

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_s_tick(i_s_tick),
    .i_rx    (i_rx),
    .s       (s),
    .rx_s    (rx_s),
    .vote    (vote)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin : p_fsm
    if (i_reset) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      shreg          <= '0;
      frame_pend     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_pend    <= 1'b0;
`endif
      o_data         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_parity_err   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_rx_done_tick <= 1'b0;
      if (i_s_tick) begin
        case (state)
          IDLE: begin
            s <= '0;
            if (!rx_s) begin
              state      <= START;
              n          <= '0;
              frame_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
              parity_pend <= 1'b0;
`endif
              o_busy     <= 1'b1;
            end
          end
          START: begin
            if ((s == S_DECIDE) && vote) begin
              state  <= IDLE;
              s      <= '0;
              o_busy <= 1'b0;
            end else if (s == S_LAST) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              s <= s + SW'(1);
            end
          end
          DATA: begin
            if (s == S_DECIDE) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (s == S_LAST) begin
              s <= '0;
              if (n == N_DATA_LAST) begin
                n <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (s == S_DECIDE) parity_pend <= (^shreg ^ vote) != 1'(PARITY_ODD);
            if (s == S_LAST) begin
              state <= STOP;
              s     <= '0;
            end else begin
              s <= s + SW'(1);
            end
          end
`endif
          // Last stop bit completes the word at its decision point
          STOP: begin
            if (s == S_DECIDE) begin
              if (n == N_STOP_LAST) begin
                o_data         <= shreg;
                o_frame_err    <= frame_pend | ~vote;
`ifdef UART_RX_PARITY_EN
                o_parity_err   <= parity_pend;
`else
                o_parity_err   <= 1'b0;
`endif
                o_rx_done_tick <= 1'b1;
                s              <= '0;
                n              <= '0;
                if (frame_pend | ~vote) begin
                  state <= BREAK;
                end else begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
                end
              end else begin
                frame_pend <= frame_pend | ~vote;
                s          <= s + SW'(1);
              end
            end else if (s == S_LAST) begin
              s <= '0;
              n <= n + NW'(1);
            end else begin
              s <= s + SW'(1);
            end
          end
          BREAK: begin
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            s      <= '0;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
